// File: rtl/proc_pkg.sv
// Shared opcodes, timestep encodings and register select helper
// for the multicycle processor control path.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  // Bus mux expects R0 on bit 7 down to R7 on bit 0.
  function automatic logic [7:0] reg_onehot(input logic [2:0] r);
    return 8'h80 >> r;
  endfunction

endpackage

// File: rtl/proc_step_counter.sv
// Timestep register with synchronous clear and the memory
// wait down-counter used while a load is outstanding.
module proc_step_counter
  import proc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  tstep_t     step_nxt,
  input  logic       cnt_load,
  input  logic       cnt_dec,
  output tstep_t     step,
  output logic [2:0] cnt
);

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      step <= T0;
      cnt  <= '0;
    end else begin
      step <= step_nxt;
      if (cnt_load)
        cnt <= 3'(MEM_WAIT);
      else if (cnt_dec)
        cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multicycle control FSM: fetches IR, then sequences bus selects
// and register loads over T0-T3, pulsing Done on the last step.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [15:0] DIN,
  input  logic        Gnz,
  output logic        IRin,
  output logic [7:0]  Rout,
  output logic [7:0]  Rin,
  output logic        Gout,
  output logic        DINout,
  output logic        Memout,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        ADDRin,
  output logic        DOUTin,
  output logic        W_D,
  output logic        Done
);

  logic [15:0] ir;
  logic [2:0]  op;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [7:0]  x_oh;
  logic [7:0]  y_oh;
  logic        unused_ir;
  logic        is_alu;

  tstep_t      step;
  tstep_t      step_nxt;
  logic [2:0]  cnt;
  logic        cnt_load;
  logic        cnt_dec;

  assign op        = ir[15:13];
  assign rx        = ir[12:10];
  assign ry        = ir[9:7];
  assign x_oh      = reg_onehot(rx);
  assign y_oh      = reg_onehot(ry);
  assign unused_ir = ^ir[6:0];
  assign is_alu    = (op == OP_ADD) || (op == OP_SUB);

  always_ff @(posedge Clock) begin
    if (Resetn)
      ir <= '0;
    else if (IRin)
      ir <= DIN;
  end

  proc_step_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_step (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .step_nxt (step_nxt),
    .cnt_load (cnt_load),
    .cnt_dec  (cnt_dec),
    .step     (step),
    .cnt      (cnt)
  );

  always_comb begin
    IRin     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    Memout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    AddSub   = 1'b0;
    ADDRin   = 1'b0;
    DOUTin   = 1'b0;
    W_D      = 1'b0;
    Done     = 1'b0;
    step_nxt = step;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    // Reset holds every strobe low, IRin included.
    if (!Resetn) begin
      unique case (step)
        T0: begin
          if (Run) begin
            IRin     = 1'b1;
            step_nxt = T1;
          end
        end
        T1: begin
          unique case (op)
            OP_MV: begin
              Rout     = y_oh;
              Rin      = x_oh;
              Done     = 1'b1;
              step_nxt = T0;
            end
            OP_MVI: begin
              DINout   = 1'b1;
              Rin      = x_oh;
              Done     = 1'b1;
              step_nxt = T0;
            end
            OP_ADD, OP_SUB: begin
              Rout     = x_oh;
              Ain      = 1'b1;
              step_nxt = T2;
            end
            OP_LD: begin
              Rout     = y_oh;
              ADDRin   = 1'b1;
              cnt_load = 1'b1;
              step_nxt = (MEM_WAIT == 0) ? T3 : T2;
            end
            OP_ST: begin
              Rout     = y_oh;
              ADDRin   = 1'b1;
              step_nxt = T2;
            end
            OP_MVNZ: begin
              if (Gnz) begin
                Rout = y_oh;
                Rin  = x_oh;
              end
              Done     = 1'b1;
              step_nxt = T0;
            end
            OP_NOP: begin
              Done     = 1'b1;
              step_nxt = T0;
            end
          endcase
        end
        T2: begin
          if (is_alu) begin
            Rout     = y_oh;
            Gin      = 1'b1;
            AddSub   = op[0];
            step_nxt = T3;
          end else if (op == OP_LD) begin
            cnt_dec  = 1'b1;
            // Leave once the final wait cycle is in progress.
            if (cnt <= 3'd1)
              step_nxt = T3;
          end else if (op == OP_ST) begin
            Rout     = x_oh;
            DOUTin   = 1'b1;
            W_D      = 1'b1;
            Done     = 1'b1;
            step_nxt = T0;
          end else begin
            step_nxt = T0;
          end
        end
        T3: begin
          if (is_alu) begin
            Gout = 1'b1;
            Rin  = x_oh;
            Done = 1'b1;
          end else if (op == OP_LD) begin
            Memout = 1'b1;
            Rin    = x_oh;
            Done   = 1'b1;
          end
          step_nxt = T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: per-cycle expected
// strobe vectors queued with stimulus, compared as they emerge.
module tb_proc_control_unit;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic        gnz;
    logic [15:0] din;
    logic [26:0] exp;
  } stim_t;

  localparam logic [26:0] Z      = '0;
  localparam logic [9:0]  F_GOUT = 10'h200;
  localparam logic [9:0]  F_DIN  = 10'h100;
  localparam logic [9:0]  F_MEM  = 10'h080;
  localparam logic [9:0]  F_AIN  = 10'h040;
  localparam logic [9:0]  F_GIN  = 10'h020;
  localparam logic [9:0]  F_SUB  = 10'h010;
  localparam logic [9:0]  F_ADDR = 10'h008;
  localparam logic [9:0]  F_DOUT = 10'h004;
  localparam logic [9:0]  F_WD   = 10'h002;
  localparam logic [9:0]  F_DONE = 10'h001;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Run;
  logic        Run0;
  logic        Gnz;
  logic [15:0] DIN;
  logic        use0;

  logic        m_IRin, m_Gout, m_DINout, m_Memout, m_Ain, m_Gin;
  logic        m_AddSub, m_ADDRin, m_DOUTin, m_WD, m_Done;
  logic [7:0]  m_Rout, m_Rin;
  logic        z_IRin, z_Gout, z_DINout, z_Memout, z_Ain, z_Gin;
  logic        z_AddSub, z_ADDRin, z_DOUTin, z_WD, z_Done;
  logic [7:0]  z_Rout, z_Rin;

  logic [26:0] obs_m, obs_z, obs;

  int n_chk = 0;
  int n_fail = 0;
  int inv_chk = 0;
  int inv_fail = 0;
  int n_start = 0;
  int n_done = 0;
  logic done_q = 1'b0;

  stim_t sq[$];

  always #5 Clock = ~Clock;

  proc_control_unit #(.MEM_WAIT(2)) dut (
    .Clock (Clock), .Resetn (Resetn), .Run (Run), .DIN (DIN),
    .Gnz (Gnz), .IRin (m_IRin), .Rout (m_Rout), .Rin (m_Rin),
    .Gout (m_Gout), .DINout (m_DINout), .Memout (m_Memout),
    .Ain (m_Ain), .Gin (m_Gin), .AddSub (m_AddSub),
    .ADDRin (m_ADDRin), .DOUTin (m_DOUTin), .W_D (m_WD),
    .Done (m_Done)
  );

  proc_control_unit #(.MEM_WAIT(0)) dut0 (
    .Clock (Clock), .Resetn (Resetn), .Run (Run0), .DIN (DIN),
    .Gnz (Gnz), .IRin (z_IRin), .Rout (z_Rout), .Rin (z_Rin),
    .Gout (z_Gout), .DINout (z_DINout), .Memout (z_Memout),
    .Ain (z_Ain), .Gin (z_Gin), .AddSub (z_AddSub),
    .ADDRin (z_ADDRin), .DOUTin (z_DOUTin), .W_D (z_WD),
    .Done (z_Done)
  );

  assign obs_m = {m_IRin, m_Rout, m_Rin, m_Gout, m_DINout, m_Memout,
                  m_Ain, m_Gin, m_AddSub, m_ADDRin, m_DOUTin, m_WD,
                  m_Done};
  assign obs_z = {z_IRin, z_Rout, z_Rin, z_Gout, z_DINout, z_Memout,
                  z_Ain, z_Gin, z_AddSub, z_ADDRin, z_DOUTin, z_WD,
                  z_Done};
  assign obs = use0 ? obs_z : obs_m;

  always @(negedge Clock) begin
    inv_chk <= inv_chk + 1;
    if ((int'(m_Rout != 0) + int'(m_Gout) + int'(m_DINout)
         + int'(m_Memout)) > 1
        || (m_Rout & (m_Rout - 8'd1)) != 0
        || (m_Rin & (m_Rin - 8'd1)) != 0
        || (m_WD && !m_DOUTin)
        || (m_Done && done_q)) begin
      inv_fail <= inv_fail + 1;
      $display("FAIL invariant t=%0t: vec %h", $time, obs_m);
    end
    done_q  <= m_Done;
    n_done  <= n_done + int'(m_Done);
    n_start <= n_start + int'(m_IRin);
  end

  function automatic logic [26:0] mk(input logic irin,
                                     input logic [7:0] ro,
                                     input logic [7:0] ri,
                                     input logic [9:0] f);
    return {irin, ro, ri, f};
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] op,
                                      input logic [2:0] x,
                                      input logic [2:0] y);
    return {op, x, y, 7'h55};
  endfunction

  task automatic push(input logic rst, input logic run,
                      input logic gnz, input logic [15:0] din,
                      input logic [26:0] exp);
    stim_t s;
    s = '{rst: rst, run: run, gnz: gnz, din: din, exp: exp};
    sq.push_back(s);
  endtask

  task automatic drive(input stim_t s);
    @(posedge Clock);
    #1;
    Resetn = s.rst;
    Run    = use0 ? 1'b0 : s.run;
    Run0   = use0 ? s.run : 1'b0;
    Gnz    = s.gnz;
    DIN    = s.din;
    #2;
  endtask

  task automatic test_reset();
    stim_t s;
    push(1, 1, 0, enc(3'b000, 0, 1), Z);
    push(1, 1, 0, enc(3'b000, 0, 1), Z);
    push(0, 1, 0, enc(3'b000, 0, 1), mk(1, 0, 0, 0));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL reset: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_mv();
    stim_t s;
    push(0, 0, 0, 16'hFFFF, mk(0, 8'h40, 8'h80, F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL mv: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_mvi();
    stim_t s;
    push(0, 1, 0, enc(3'b001, 5, 0), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h1234, mk(0, 0, 8'h04, F_DIN | F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL mvi: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_sub();
    stim_t s;
    push(0, 1, 0, enc(3'b011, 3, 2), mk(1, 0, 0, 0));
    push(0, 1, 0, 16'h0000, mk(0, 8'h10, 0, F_AIN));
    push(0, 0, 0, 16'h0000, mk(0, 8'h20, 0, F_GIN | F_SUB));
    push(0, 1, 0, 16'h0000, mk(0, 0, 8'h10, F_GOUT | F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL sub: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_ld();
    stim_t s;
    push(0, 1, 0, enc(3'b100, 4, 5), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 8'h04, 0, F_ADDR));
    push(0, 0, 0, 16'h0000, Z);
    push(0, 0, 0, 16'h0000, Z);
    push(0, 0, 0, 16'h0000, mk(0, 0, 8'h08, F_MEM | F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL ld_wait2: got %h want %h", obs, s.exp);
      end
    end
    use0 = 1'b1;
    push(0, 1, 0, enc(3'b100, 4, 5), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 8'h04, 0, F_ADDR));
    push(0, 0, 0, 16'h0000, mk(0, 0, 8'h08, F_MEM | F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL ld_wait0: got %h want %h", obs, s.exp);
      end
    end
    use0 = 1'b0;
  endtask

  task automatic test_st();
    stim_t s;
    push(0, 1, 0, enc(3'b101, 6, 7), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 8'h01, 0, F_ADDR));
    push(0, 0, 0, 16'h0000,
         mk(0, 8'h02, 0, F_DOUT | F_WD | F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL st: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_mvnz();
    stim_t s;
    push(0, 1, 0, enc(3'b110, 2, 3), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 0, 0, F_DONE));
    push(0, 1, 1, enc(3'b110, 2, 3), mk(1, 0, 0, 0));
    push(0, 0, 1, 16'h0000, mk(0, 8'h10, 8'h20, F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL mvnz: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_nop_add_same();
    stim_t s;
    push(0, 1, 0, enc(3'b111, 0, 0), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 0, 0, F_DONE));
    push(0, 1, 0, enc(3'b010, 1, 1), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 8'h40, 0, F_AIN));
    push(0, 0, 0, 16'h0000, mk(0, 8'h40, 0, F_GIN));
    push(0, 0, 0, 16'h0000, mk(0, 0, 8'h40, F_GOUT | F_DONE));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL nop_add: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_abort();
    stim_t s;
    push(0, 1, 0, enc(3'b010, 2, 5), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 8'h20, 0, F_AIN));
    push(1, 0, 0, 16'h0000, Z);
    push(0, 0, 0, 16'h0000, Z);
    push(0, 1, 0, enc(3'b111, 0, 0), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'h0000, mk(0, 0, 0, F_DONE));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL abort: got %h want %h", obs, s.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    push(0, 1, 0, enc(3'b000, 7, 0), mk(1, 0, 0, 0));
    push(0, 1, 0, enc(3'b001, 3, 0), mk(0, 8'h80, 8'h01, F_DONE));
    push(0, 1, 0, enc(3'b001, 3, 0), mk(1, 0, 0, 0));
    push(0, 0, 0, 16'hBEEF, mk(0, 0, 8'h10, F_DIN | F_DONE));
    push(0, 0, 0, 16'h0000, Z);
    while (sq.size() != 0) begin
      s = sq.pop_front();
      drive(s);
      n_chk++;
      if (obs !== s.exp) begin
        n_fail++;
        $display("FAIL b2b: got %h want %h", obs, s.exp);
      end
    end
  endtask

  initial begin
    Resetn = 1'b1;
    Run    = 1'b0;
    Run0   = 1'b0;
    Gnz    = 1'b0;
    DIN    = '0;
    use0   = 1'b0;
    test_reset();
    test_mv();
    test_mvi();
    test_sub();
    test_ld();
    test_st();
    test_mvnz();
    test_nop_add_same();
    test_abort();
    test_back_to_back();
    @(negedge Clock);
    #1;
    n_chk++;
    if (n_start !== 13) begin
      n_fail++;
      $display("FAIL start_count: got %0d want 13", n_start);
    end
    n_chk++;
    if (n_done !== 12) begin
      n_fail++;
      $display("FAIL done_count: got %0d want 12", n_done);
    end
    n_chk  = n_chk + inv_chk;
    n_fail = n_fail + inv_fail;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
